pico_ctrl: RTL and testbench

Multicycle control unit for the pico MIPS core. It fetches instructions, decodes them and issues the ALU function codes and operand selects that the ALU consumes. It owns the program counter, register-file write control, branch resolution from the ALU zero flag, and the valid/ready I/O handshakes. It sits between instruction memory, the register file and the ALU.

---
 rtl/pico_ctrl_if.sv | 48 ++++
 rtl/pico_ctrl.sv | 121 ++++++++++++
 tb/tb_pico_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pico_ctrl_if.sv
// Bus between the pico control unit and its imem / regfile / ALU / I/O neighbours.
// The alucodes live here so every consumer of the bus sees one encoding.
`ifndef PICO_ALUCODES
`define PICO_ALUCODES
`define RA   3'd0
`define RB   3'd1
`define RADD 3'd2
`define RSUB 3'd3
`define RAND 3'd4
`define ROR  3'd5
`define RXOR 3'd6
`define RMUL 3'd7
`endif

interface pico_ctrl_if #(
    parameter int PC_W    = 8,
    parameter int N       = 8,
    parameter int INSTR_W = 20
);
    logic [PC_W-1:0]    instr_addr;
    logic [INSTR_W-1:0] instr;
    logic               zf;
    logic [2:0]         alu_func;
    logic [N-1:0]       imm;
    logic               b_sel;
    logic               wd_sel;
    logic [2:0]         ra_addr;
    logic [2:0]         rb_addr;
    logic [2:0]         wa;
    logic               we;
    logic               in_valid;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic               halted;

    modport master (
        output instr_addr, alu_func, imm, b_sel, wd_sel, ra_addr, rb_addr, wa, we,
               in_ready, out_valid, halted,
        input  instr, zf, in_valid, out_ready
    );

    modport slave (
        input  instr_addr, alu_func, imm, b_sel, wd_sel, ra_addr, rb_addr, wa, we,
               in_ready, out_valid, halted,
        output instr, zf, in_valid, out_ready
    );
endinterface

// File: rtl/pico_ctrl.sv
// Multicycle FETCH/EXEC control unit for the pico MIPS core: owns pc and ir,
// decodes ALU controls and regfile writes, resolves branches, runs the I/O handshakes.
module pico_ctrl #(
    parameter int PC_W    = 8,
    parameter int N       = 8,
    parameter int INSTR_W = 20
) (
    input logic          clk,
    input logic          n_reset,
    pico_ctrl_if.master  bus
);
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_SUBI = 4'h4;
    localparam logic [3:0] OP_MULI = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_J    = 4'hC;
    localparam logic [3:0] OP_IN   = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT} state_t;

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;

    logic [3:0]      op;
    logic [2:0]      rd, rs;
    logic [N-1:0]    imm_f;
    logic            unused_bits;
    logic [2:0]      dec_func;
    logic            dec_bsel, dec_wr, taken;
    logic [PC_W-1:0] pc_inc, br_tgt, j_tgt;

    assign op          = ir[19:16];
    assign rd          = ir[15:13];
    assign rs          = ir[12:10];
    assign imm_f       = ir[N-1:0];
    assign unused_bits = ^ir[9:8];

    assign pc_inc = pc + PC_W'(1);
    assign br_tgt = pc + PC_W'($signed(imm_f));
    assign j_tgt  = PC_W'(imm_f);
    assign taken  = (op == OP_BEQ) ? bus.zf : ~bus.zf;

    always_comb begin
        dec_func = `RA;
        dec_bsel = 1'b0;
        dec_wr   = 1'b0;
        case (op)
            OP_ADD:          begin dec_func = `RADD; dec_wr = 1'b1; end
            OP_ADDI:         begin dec_func = `RADD; dec_wr = 1'b1; dec_bsel = 1'b1; end
            OP_SUB:          begin dec_func = `RSUB; dec_wr = 1'b1; end
            OP_SUBI:         begin dec_func = `RSUB; dec_wr = 1'b1; dec_bsel = 1'b1; end
            OP_MULI:         begin dec_func = `RMUL; dec_wr = 1'b1; dec_bsel = 1'b1; end
            OP_AND:          begin dec_func = `RAND; dec_wr = 1'b1; end
            OP_OR:           begin dec_func = `ROR;  dec_wr = 1'b1; end
            OP_XOR:          begin dec_func = `RXOR; dec_wr = 1'b1; end
            OP_LDI:          begin dec_func = `RB;   dec_wr = 1'b1; dec_bsel = 1'b1; end
            OP_BEQ, OP_BNE:  dec_func = `RSUB;
            default:         ;
        endcase
    end

    // Outputs are pure decode of state/ir, so an async reset drops them at once.
    assign bus.instr_addr = pc;
    assign bus.alu_func   = (state == EXEC) ? dec_func : `RA;
    assign bus.b_sel      = (state == EXEC) & dec_bsel;
    assign bus.wd_sel     = (state == WAIT_IN);
    assign bus.imm        = imm_f;
    assign bus.ra_addr    = rd;
    assign bus.rb_addr    = rs;
    assign bus.wa         = rd;
    assign bus.we         = ((state == EXEC) & dec_wr) | ((state == WAIT_IN) & bus.in_valid);
    assign bus.in_ready   = (state == WAIT_IN);
    assign bus.out_valid  = (state == WAIT_OUT);
    assign bus.halted     = (state == HALT);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= bus.instr;
                    state <= EXEC;
                end
                EXEC: begin
                    state <= FETCH;
                    case (op)
                        OP_BEQ, OP_BNE: pc <= taken ? br_tgt : pc_inc;
                        OP_J:           pc <= j_tgt;
                        OP_IN:          state <= WAIT_IN;
                        OP_OUT:         state <= WAIT_OUT;
                        OP_HALT:        state <= HALT;
                        default:        pc <= pc_inc;
                    endcase
                end
                WAIT_IN: if (bus.in_valid) begin
                    pc    <= pc_inc;
                    state <= FETCH;
                end
                WAIT_OUT: if (bus.out_ready) begin
                    pc    <= pc_inc;
                    state <= FETCH;
                end
                HALT:    ;
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_pico_ctrl.sv
// Bench for pico_ctrl: an instruction-level program model queues the observable
// events (reg writes, I/O transfers, halt) and a monitor matches them as they happen.
module tb_pico_ctrl;
    localparam logic [2:0] F_RA = 3'd0, F_RB = 3'd1, F_ADD = 3'd2, F_SUB = 3'd3,
                           F_AND = 3'd4, F_OR = 3'd5, F_XOR = 3'd6, F_MUL = 3'd7;
    localparam int K_W = 1, K_IN = 2, K_O = 3, K_H = 4;

    typedef struct {
        int         kind;
        logic [7:0] pc;
        logic [2:0] func;
        logic       bsel;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] imm;
    } ev_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic hs_rand = 1'b0;
    logic iv_man = 1'b0, or_man = 1'b0, iv_rnd = 1'b0, or_rnd = 1'b0;
    logic [19:0] mem [256];
    logic        zmap [256];
    ev_t q[$];
    int checks = 0;
    int errors = 0;
    logic hprev = 1'b0;

    pico_ctrl_if #(.PC_W(8), .N(8), .INSTR_W(20)) bus ();

    pico_ctrl #(.PC_W(8), .N(8), .INSTR_W(20)) dut (
        .clk(clk), .n_reset(n_reset), .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.instr     = mem[bus.instr_addr];
    assign bus.zf        = zmap[bus.instr_addr];
    assign bus.in_valid  = hs_rand ? iv_rnd : iv_man;
    assign bus.out_ready = hs_rand ? or_rnd : or_man;

    always @(posedge clk) begin
        #1;
        iv_rnd = ($urandom_range(0, 2) == 0);
        or_rnd = ($urandom_range(0, 2) == 0);
    end

    function automatic logic [19:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [7:0] imm);
        return {op, rd, rs, 2'b00, imm};
    endfunction

    // Instruction-level reference: walk the program, queue what the outside world sees.
    task automatic model_run(input int maxn);
        logic [7:0] pc = 8'h00;
        for (int n = 0; n < maxn; n++) begin
            logic [19:0] i = mem[pc];
            logic [3:0] op = i[19:16];
            ev_t e;
            e.kind = 0; e.pc = pc; e.rd = i[15:13]; e.rs = i[12:10]; e.imm = i[7:0];
            e.bsel = (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h9);
            case (op)
                4'h1, 4'h2: e.func = F_ADD;
                4'h3, 4'h4: e.func = F_SUB;
                4'h5:       e.func = F_MUL;
                4'h6:       e.func = F_AND;
                4'h7:       e.func = F_OR;
                4'h8:       e.func = F_XOR;
                4'h9:       e.func = F_RB;
                default:    e.func = F_RA;
            endcase
            if (op >= 4'h1 && op <= 4'h9) begin
                e.kind = K_W; q.push_back(e); pc = pc + 8'd1;
            end else if (op == 4'hA || op == 4'hB) begin
                if (zmap[pc] == (op == 4'hA)) pc = pc + i[7:0];
                else pc = pc + 8'd1;
            end else if (op == 4'hC) pc = i[7:0];
            else if (op == 4'hD) begin e.kind = K_IN; q.push_back(e); pc = pc + 8'd1; end
            else if (op == 4'hE) begin e.kind = K_O; q.push_back(e); pc = pc + 8'd1; end
            else if (op == 4'hF) begin e.kind = K_H; q.push_back(e); break; end
            else pc = pc + 8'd1;
        end
    endtask

    always @(negedge clk) begin
        int k;
        ev_t e;
        bit ok;
        if (!n_reset) hprev = 1'b0;
        else begin
            k = 0;
            if (bus.halted && !hprev)        k = K_H;
            else if (bus.we && bus.in_ready) k = K_IN;
            else if (bus.we)                 k = K_W;
            else if (bus.out_valid && bus.out_ready) k = K_O;
            hprev = bus.halted;
            if (k != 0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event kind=%0d pc=%0h (no event expected)", k, bus.instr_addr);
                end else begin
                    e = q.pop_front();
                    ok = (e.kind == k) && (e.pc == bus.instr_addr);
                    if (k == K_W)
                        ok = ok && bus.alu_func == e.func && bus.b_sel == e.bsel && !bus.wd_sel &&
                             bus.wa == e.rd && bus.ra_addr == e.rd && bus.rb_addr == e.rs && bus.imm == e.imm;
                    if (k == K_IN) ok = ok && bus.wd_sel && bus.wa == e.rd;
                    if (k == K_O)  ok = ok && bus.alu_func == F_RA && bus.ra_addr == e.rd;
                    if (!ok) begin
                        errors++;
                        $display("FAIL event got kind=%0d pc=%0h func=%0d bsel=%0b wd=%0b wa=%0d rb=%0d imm=%0h exp kind=%0d pc=%0h func=%0d bsel=%0b rd=%0d rs=%0d imm=%0h",
                                 k, bus.instr_addr, bus.alu_func, bus.b_sel, bus.wd_sel, bus.wa, bus.rb_addr, bus.imm,
                                 e.kind, e.pc, e.func, e.bsel, e.rd, e.rs, e.imm);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        n_reset = 1'b0; iv_man = 1'b0; or_man = 1'b0;
        q.delete();
        @(negedge clk); #1;
        chk("reset_outs", {bus.we, bus.in_ready, bus.out_valid, bus.halted, bus.alu_func, bus.instr_addr},
            {4'b0000, F_RA, 8'h00});
    endtask

    task automatic release_rst();
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic fill_halt();
        for (int a = 0; a < 256; a++) begin
            mem[a] = enc(4'hF, 3'd0, 3'd0, 8'h00);
            zmap[a] = 1'b0;
        end
    endtask

    task automatic run_wait(input string name, input int budget);
        int c = 0;
        while (q.size() != 0 && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        chk({name, "_drain"}, q.size(), 0);
    endtask

    task automatic wait_sig(input int which, input string name);
        int c = 0;
        bit seen = 0;
        while (!seen && c < 50) begin
            @(negedge clk); #1;
            seen = (which == 0) ? bus.in_ready : (which == 1) ? bus.out_valid : bus.halted;
            c++;
        end
        chk({name, "_seen"}, seen, 1);
    endtask

    initial begin
        logic [7:0] hpc;
        bit hok;
        int rdy;
        // ALU op sequence with exact ADDI timing, then HALT freeze
        fill_halt();
        mem[0] = enc(4'h2, 3'd1, 3'd0, 8'h05);
        mem[1] = enc(4'h9, 3'd2, 3'd0, 8'h33);
        mem[2] = enc(4'h3, 3'd3, 3'd2, 8'h00);
        mem[3] = enc(4'h6, 3'd4, 3'd1, 8'h00);
        mem[4] = enc(4'h7, 3'd5, 3'd2, 8'h00);
        mem[5] = enc(4'h8, 3'd6, 3'd3, 8'h00);
        mem[6] = enc(4'h5, 3'd7, 3'd0, 8'h03);
        do_reset();
        model_run(20);
        release_rst(); #1;
        chk("fetch_cycle", {bus.we, bus.alu_func, bus.instr_addr}, {1'b0, F_RA, 8'h00});
        @(negedge clk); #1;
        chk("addi_exec", {bus.alu_func, bus.b_sel, bus.imm, bus.wa, bus.we}, {F_ADD, 1'b1, 8'h05, 3'd1, 1'b1});
        @(negedge clk); #1;
        chk("addi_pc", {bus.we, bus.instr_addr}, {1'b0, 8'h01});
        run_wait("seq", 200);
        hpc = bus.instr_addr; hok = 1;
        iv_man = 1'b1; or_man = 1'b1;
        repeat (20) begin
            @(negedge clk); #1;
            if (!bus.halted || bus.instr_addr != hpc || bus.we) hok = 0;
        end
        chk("halt_frozen", {hok, hpc}, {1'b1, 8'h07});

        // Branch resolution at pc=10, offset -4
        for (int b = 0; b < 4; b++) begin
            fill_halt();
            mem[0]  = enc(4'hC, 3'd0, 3'd0, 8'd10);
            mem[10] = enc((b < 2) ? 4'hA : 4'hB, 3'd1, 3'd2, 8'hFC);
            mem[6]  = enc(4'hE, 3'd6, 3'd0, 8'h00);
            mem[11] = enc(4'hE, 3'd3, 3'd0, 8'h00);
            zmap[10] = (b % 2 == 0);
            do_reset();
            hs_rand = 1'b1;
            model_run(20);
            chk("branch_target", q[0].pc, (b == 0 || b == 3) ? 8'd6 : 8'd11);
            release_rst();
            run_wait("branch", 300);
            hs_rand = 1'b0;
        end

        // IN at pc=3 with in_valid late by four cycles
        fill_halt();
        mem[0] = 20'h0; mem[1] = 20'h0; mem[2] = 20'h0;
        mem[3] = enc(4'hD, 3'd2, 3'd0, 8'h00);
        do_reset();
        model_run(20);
        release_rst();
        wait_sig(0, "in_ready");
        rdy = 1; hok = !bus.we;
        repeat (3) begin
            @(negedge clk); #1;
            if (bus.in_ready) rdy++;
            if (bus.we || !bus.wd_sel) hok = 0;
        end
        @(posedge clk); #1; iv_man = 1'b1;
        @(negedge clk); #1;
        if (bus.in_ready) rdy++;
        chk("in_wait_we_low", hok, 1);
        chk("in_accept", {bus.we, bus.wd_sel, bus.wa}, {1'b1, 1'b1, 3'd2});
        @(posedge clk); #1; iv_man = 1'b0;
        chk("in_ready_cycles", rdy, 5);
        chk("in_pc", bus.instr_addr, 8'd4);
        run_wait("in", 50);

        // OUT with out_ready late by three cycles
        fill_halt();
        mem[0] = enc(4'hE, 3'd5, 3'd0, 8'h00);
        do_reset();
        model_run(20);
        release_rst();
        wait_sig(1, "out_valid");
        hok = 1;
        repeat (2) begin
            @(negedge clk); #1;
            if (!bus.out_valid || bus.alu_func != F_RA || bus.instr_addr != 8'd0) hok = 0;
        end
        @(posedge clk); #1; or_man = 1'b1;
        @(negedge clk); #1;
        chk("out_hold", {hok, bus.out_valid, bus.instr_addr}, {1'b1, 1'b1, 8'd0});
        @(posedge clk); #1; or_man = 1'b0;
        chk("out_pc", {bus.out_valid, bus.instr_addr}, {1'b0, 8'd1});
        run_wait("out", 50);

        // J to 0xFE, LDI, NOP at 0xFF wraps pc to 0 and loops
        fill_halt();
        mem[0]   = enc(4'hC, 3'd0, 3'd0, 8'hFE);
        mem[254] = enc(4'h9, 3'd4, 3'd0, 8'hA5);
        mem[255] = 20'h0;
        do_reset();
        model_run(7);
        release_rst();
        run_wait("wrap", 100);

        // Reset in the middle of WAIT_IN
        fill_halt();
        mem[0] = enc(4'hD, 3'd1, 3'd0, 8'h00);
        do_reset();
        release_rst();
        wait_sig(0, "rst_in_ready");
        n_reset = 1'b0; #1;
        chk("rst_drop", {bus.in_ready, bus.we, bus.wd_sel}, 3'b000);
        iv_man = 1'b1; #1;
        chk("rst_no_we", bus.we, 0);
        iv_man = 1'b0;
        release_rst(); #1;
        chk("rst_restart", {bus.instr_addr, bus.in_ready, bus.alu_func}, {8'h00, 1'b0, F_RA});
        @(negedge clk); #1;
        chk("rst_exec", bus.in_ready, 0);
        @(negedge clk); #1;
        chk("rst_rewait", bus.in_ready, 1);

        // Random programs with random zf map and random handshakes
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 256; a++) begin
                logic [3:0] op;
                op = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
                mem[a] = {op, 3'($urandom), 3'($urandom), 2'($urandom), 8'($urandom)};
                zmap[a] = 1'($urandom);
            end
            do_reset();
            hs_rand = 1'b1;
            model_run(80);
            release_rst();
            run_wait("random", 3000);
            hs_rand = 1'b0;
        end

        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
